// File: rtl/fibonacci_index_if.sv
// Start/done handshake bundle shared with the Fibonacci generator.
interface fibonacci_index_if #(
    parameter int unsigned DATA_WIDTH = 4
);
    localparam int unsigned FW = 2 * DATA_WIDTH + 2;

    logic                  start;
    logic [FW-1:0]         f;
    logic                  done;
    logic                  busy;
    logic [DATA_WIDTH-1:0] n;
    logic                  exact;
    logic                  ovf;

    // Requester side: issues start/f, observes the result.
    modport master (
        output start, f,
        input  done, busy, n, exact, ovf
    );

    // Decoder side: accepts start/f, drives the result.
    modport slave (
        input  start, f,
        output done, busy, n, exact, ovf
    );
endinterface

// File: rtl/fibonacci_index.sv
// Fibonacci index decoder: finds n with F(n) the largest Fibonacci number <= f.
// Walks the sequence one term per cycle until it meets or passes f, or runs
// out of index range. Optional macro FIB_INDEX_ROUND_UP_EN makes non-exact
// results report the index of the next larger Fibonacci number instead.
module fibonacci_index #(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    fibonacci_index_if.slave   bus
);
    localparam int unsigned FW = 2 * DATA_WIDTH + 2;
    // One extra bit so a+b cannot wrap before it is compared with f.
    localparam int unsigned BW = FW + 1;

    localparam logic [DATA_WIDTH-1:0] IDX_ONE = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] IDX_MAX = '1;

`ifdef FIB_INDEX_ROUND_UP_EN
    localparam bit ROUND_UP = 1'b1;
`else
    localparam bit ROUND_UP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [FW-1:0]         r_f;
    logic [BW-1:0]         r_a;
    logic [BW-1:0]         r_b;
    logic [DATA_WIDTH-1:0] r_i;
    logic [DATA_WIDTH-1:0] r_n;
    logic                  r_exact;
    logic                  r_ovf;
    logic                  r_done;
    logic                  r_busy;

    logic [BW-1:0]         w_f_ext;
    logic [BW-1:0]         w_sum;
    logic [DATA_WIDTH-1:0] w_n_inexact;

    // Operand alignment, next term and the index reported when f is passed.
    assign w_f_ext     = BW'(r_f);
    assign w_sum       = r_a + r_b;
    assign w_n_inexact = ROUND_UP ? r_i : (r_i - IDX_ONE);

    // Control FSM with sequence registers and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_f     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_i     <= '0;
            r_n     <= '0;
            r_exact <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_f     <= bus.f;
                        r_a     <= '0;
                        r_b     <= BW'(1);
                        r_i     <= IDX_ONE;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_f == '0) begin
                        r_n     <= '0;
                        r_exact <= 1'b1;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_b == w_f_ext) begin
                        r_n     <= r_i;
                        r_exact <= 1'b1;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_b > w_f_ext) begin
                        r_n     <= w_n_inexact;
                        r_exact <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_i == IDX_MAX) begin
                        r_n     <= IDX_MAX;
                        r_exact <= 1'b0;
                        r_ovf   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_a <= r_b;
                        r_b <= w_sum;
                        r_i <= r_i + IDX_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result and status outputs, all straight from registers.
    assign bus.done  = r_done;
    assign bus.busy  = r_busy;
    assign bus.n     = r_n;
    assign bus.exact = r_exact;
    assign bus.ovf   = r_ovf;
endmodule
